// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port unified memory arbiter for fetch and load/store
// One transaction in flight at a time, D has priority, with a fetch starvation guard, fence drain and halt.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              halt,
    input  logic              fence_req,
    output logic              fence_done,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [3:0]    LAT  = 4'(MEM_LAT);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_d_q, owner_d_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          fence_pending_q, fence_pending_d;
    logic          idle;
    logic          done;

    always_comb begin
        if_gnt          = 1'b0;
        d_gnt           = 1'b0;
        state_d         = state_q;
        cnt_d           = cnt_q;
        owner_d_d       = owner_d_q;
        streak_d        = streak_q;
        // rst_n gates the grant path so every strobe is low while reset is held
        idle            = rst_n && (state_q == IDLE);
        done            = (state_q == BUSY) && (cnt_q == LAT);
        fence_done      = idle && fence_pending_q;
        fence_pending_d = fence_done ? 1'b0 : (fence_pending_q | fence_req);

        if (idle && !fence_pending_q && !fence_req) begin
            if (d_req && (!if_req || halt || (streak_q < SMAX))) begin
                d_gnt = 1'b1;
            end else if (if_req && !halt) begin
                if_gnt = 1'b1;
            end
        end

        mem_en    = d_gnt | if_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
        mem_wdata = d_gnt ? d_wdata : '0;
        if_rvalid = done && !owner_d_q;
        d_rvalid  = done && owner_d_q;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
        halted    = halt && idle;

        if (mem_en) begin
            state_d   = BUSY;
            cnt_d     = 4'd1;
            owner_d_d = d_gnt;
        end else if (state_q == BUSY) begin
            if (done) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        if (if_gnt) begin
            streak_d = '0;
        end else if (d_gnt) begin
            if (!if_req) begin
                streak_d = '0;
            end else if (streak_q != SMAX) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            owner_d_q       <= 1'b0;
            streak_q        <= '0;
            fence_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            owner_d_q       <= owner_d_d;
            streak_q        <= streak_d;
            fence_pending_q <= fence_pending_d;
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        halt, fence_req, fence_done, halted;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .halt(halt), .fence_req(fence_req), .fence_done(fence_done), .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ctl"},
                 {24'd0, if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, fence_done, halted},
                 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; halt = 1'b0; fence_req = 1'b0; mem_rdata = 32'h0;

        // reset state
        step(); step();
        #1 check_quiet("reset");
        check_eq("reset_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        step();

        // single fetch
        if_req = 1'b1; if_addr = 32'h100;
        #1 check_eq("f_gnt", {29'd0, if_gnt, d_gnt, mem_en}, 32'b101);
        check_eq("f_addr", mem_addr, 32'h100);
        check_eq("f_we", {31'd0, mem_we}, 32'd0);
        step(); if_req = 1'b0;
        #1 check_quiet("f_c1");
        step(); if_req = 1'b1; if_addr = 32'h104; mem_rdata = 32'hCAFEF00D;
        #1 check_eq("f_rvalid", {30'd0, if_rvalid, if_gnt}, 32'b10);
        check_eq("f_rdata", if_rdata, 32'hCAFEF00D);
        step();
        #1 check_eq("f_next_gnt", {31'd0, if_gnt}, 32'd1);
        check_eq("f_next_addr", mem_addr, 32'h104);
        step(); if_req = 1'b0;
        step(); step();

        // simultaneous IF and D store
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        #1 check_eq("sim_gnt", {30'd0, if_gnt, d_gnt}, 32'b01);
        check_eq("sim_we", {31'd0, mem_we}, 32'd1);
        check_eq("sim_addr", mem_addr, 32'h40);
        check_eq("sim_wdata", mem_wdata, 32'hDEADBEEF);
        step(); d_req = 1'b0; d_we = 1'b0;
        step();
        #1 check_eq("sim_ack", {30'd0, d_rvalid, if_gnt}, 32'b10);
        step();
        #1 check_eq("sim_if_gnt", {30'd0, if_gnt, d_gnt}, 32'b10);
        check_eq("sim_if_addr", mem_addr, 32'h200);
        step(); if_req = 1'b0;
        step(); step();

        // starvation guard: 4 D grants then 1 IF, repeated
        begin
            int ng = 0;
            if_req = 1'b1; if_addr = 32'h300;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
            for (int c = 0; c < 60 && ng < 10; c++) begin
                #1;
                check_eq("one_hot", {31'd0, if_gnt & d_gnt}, 32'd0);
                if (if_gnt || d_gnt) begin
                    check_eq("starve_seq", {30'd0, if_gnt, d_gnt},
                             ((ng % 5) == 4) ? 32'b10 : 32'b01);
                    ng++;
                end
                step();
            end
            check_eq("starve_count", ng, 32'd10);
            if_req = 1'b0; d_req = 1'b0;
            step(); step();
        end

        // fence drain after a D grant
        d_req = 1'b1; d_addr = 32'h80; if_req = 1'b1;
        #1 check_eq("fn_gnt", {30'd0, if_gnt, d_gnt}, 32'b01);
        step(); fence_req = 1'b1;
        #1 check_eq("fn_busy", {29'd0, if_gnt, d_gnt, fence_done}, 32'd0);
        step(); fence_req = 1'b0;
        #1 check_eq("fn_rvalid", {29'd0, d_rvalid, if_gnt, d_gnt}, 32'b100);
        step();
        #1 check_eq("fn_done", {29'd0, fence_done, if_gnt, d_gnt}, 32'b100);
        step();
        #1 check_eq("fn_resume", {29'd0, fence_done, if_gnt, d_gnt}, 32'b001);
        step(); d_req = 1'b0; if_req = 1'b0;
        step(); step();

        // fence in the same idle cycle as a request, second pulse absorbed
        d_req = 1'b1; d_addr = 32'h88; fence_req = 1'b1;
        #1 check_eq("fs_block", {29'd0, fence_done, mem_en, d_gnt}, 32'd0);
        step();
        #1 check_eq("fs_done", {29'd0, fence_done, mem_en, d_gnt}, 32'b100);
        step(); fence_req = 1'b0;
        #1 check_eq("fs_gnt", {29'd0, fence_done, mem_en, d_gnt}, 32'b011);
        step(); d_req = 1'b0;
        #1 check_eq("fs_no_extra_done", {31'd0, fence_done}, 32'd0);
        step(); step();
        #1 check_eq("fs_idle_no_done", {31'd0, fence_done}, 32'd0);

        // halt: no fetch, D still served
        halt = 1'b1; if_req = 1'b1; if_addr = 32'h400;
        #1 check_eq("h_idle", {30'd0, if_gnt, halted}, 32'b01);
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'h12345678;
        #1 check_eq("h_dgnt", {29'd0, if_gnt, d_gnt, halted}, 32'b011);
        step(); d_req = 1'b0; d_we = 1'b0;
        #1 check_eq("h_busy", {30'd0, if_gnt, halted}, 32'b00);
        step();
        #1 check_eq("h_ack", {30'd0, d_rvalid, halted}, 32'b10);
        step();
        #1 check_eq("h_halted", {30'd0, if_gnt, halted}, 32'b01);
        halt = 1'b0;
        #1 check_eq("h_release", {30'd0, if_gnt, halted}, 32'b10);
        check_eq("h_addr", mem_addr, 32'h400);
        step(); if_req = 1'b0;
        step(); step();

        // reset mid-transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        #1 check_eq("r_gnt", {31'd0, d_gnt}, 32'd1);
        step(); d_req = 1'b0;
        rst_n = 1'b0;
        #1 check_quiet("r_inreset");
        step();
        #1 check_quiet("r_inreset2");
        rst_n = 1'b1; d_req = 1'b1; d_addr = 32'h504;
        #1 check_eq("r_regrant", {30'd0, d_rvalid, d_gnt}, 32'b01);
        check_eq("r_addr", mem_addr, 32'h504);
        step(); d_req = 1'b0; mem_rdata = 32'h0BADF00D;
        #1 check_eq("r_no_stale", {31'd0, d_rvalid}, 32'd0);
        step();
        #1 check_eq("r_new_rvalid", {31'd0, d_rvalid}, 32'd1);
        check_eq("r_rdata", d_rdata, 32'h0BADF00D);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
